// File: rtl/dsp_ctrl_wb_pkg.sv
// Shared types and constants for the write-back drain stage.
`ifndef HW_BP_OUT_BUF_DEPTH
`define HW_BP_OUT_BUF_DEPTH 10
`endif

package dsp_ctrl_wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } wb_state_e;

    localparam int WB_LEN_W = 24;

endpackage

// File: rtl/dsp_ctrl_wb_skid_fifo.sv
// Shift-register skid FIFO: entry 0 is always the registered head, so the
// stream output comes straight from a flop; push and pop may coincide.
module wb_skid_fifo
    import dsp_ctrl_wb_pkg::*;
#(
    parameter int OUT_W      = 512,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [OUT_W-1:0] push_data,
    input  logic             pop,
    output logic [OUT_W-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [OUT_W-1:0] ent [FIFO_DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] wr_idx;

    // A simultaneous pop shifts everything down, so the new word lands one slot lower.
    assign wr_idx    = pop ? (cnt_q - CNT_W'(1)) : cnt_q;
    assign head_data = ent[0];
    assign count     = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                if (pop) begin
                    ent[i] <= ent[i+1];
                end
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (push && (wr_idx == CNT_W'(i))) begin
                    ent[i] <= push_data;
                end
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (cnt_q == CNT_W'(FIFO_DEPTH))));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (cnt_q == '0)));

endmodule

// File: rtl/dsp_ctrl_wb.sv
// Write-back drain: reads a finished tile out of the output buffer under a
// credit limit and streams it downstream over valid/ready.
`ifndef HW_BP_OUT_BUF_DEPTH
`define HW_BP_OUT_BUF_DEPTH 10
`endif

module dsp_ctrl_wb
    import dsp_ctrl_wb_pkg::*;
#(
    parameter int BP_OUT_BUF_DEPTH = `HW_BP_OUT_BUF_DEPTH,
    parameter int OUT_W            = 512,
    parameter int RD_LAT           = 2,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bp_wb_tile_start,
    input  logic [BP_OUT_BUF_DEPTH-1:0] bp_wb_base,
    input  logic [WB_LEN_W-1:0]         bp_wb_len,
    output logic                        bp_out_buf_wb_en,
    output logic [BP_OUT_BUF_DEPTH-1:0] bp_out_buf_wb_addr,
    input  logic [OUT_W-1:0]            bp_out_buf_wb_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [OUT_W-1:0]            m_data,
    output logic                        m_last,
    output logic                        bp_wb_busy,
    output logic                        bp_wb_tile_end
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_state_e                   state_q, state_d;
    logic [BP_OUT_BUF_DEPTH-1:0] base_q;
    logic [WB_LEN_W-1:0]         len_q, issued_q, sent_q;
    logic                        wb_en_q;
    logic [BP_OUT_BUF_DEPTH-1:0] wb_addr_q;
    logic [RD_LAT-1:0]           vld_p;
    logic                        tile_end_q;

    logic             start_acc, pop, last_pop, issue, fifo_push;
    logic [CNT_W-1:0] fifo_cnt;
    logic [OUT_W-1:0] head_data;
    int               occ;

    function automatic int popcnt(input logic [RD_LAT-1:0] v);
        int n = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc && (bp_wb_len != '0)) state_d = RUN;
            RUN:     if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Occupancy counts every read from issue until it leaves the FIFO; the
    // word popped this cycle already frees its slot, which keeps one word per
    // cycle flowing once FIFO_DEPTH >= RD_LAT+2.
    always_comb begin
        start_acc  = (state_q == IDLE) && bp_wb_tile_start;
        m_valid    = (fifo_cnt != '0);
        pop        = m_valid && m_ready;
        m_last     = m_valid && (sent_q == (len_q - WB_LEN_W'(1)));
        last_pop   = pop && m_last;
        occ        = popcnt(vld_p) + int'(wb_en_q) + int'(fifo_cnt) - int'(pop);
        issue      = (state_q == RUN) && (issued_q < len_q) && (occ < FIFO_DEPTH);
        fifo_push  = vld_p[RD_LAT-1];
        bp_wb_busy = (state_q == RUN);
    end

    // p0: read issue and tile bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            tile_end_q <= 1'b0;
        end else begin
            tile_end_q <= (start_acc && (bp_wb_len == '0)) || last_pop;
            wb_en_q    <= issue;
            if (start_acc && (bp_wb_len != '0)) begin
                base_q   <= bp_wb_base;
                len_q    <= bp_wb_len;
                issued_q <= '0;
                sent_q   <= '0;
            end else begin
                if (issue) begin
                    wb_addr_q <= base_q + BP_OUT_BUF_DEPTH'(issued_q);
                    issued_q  <= issued_q + WB_LEN_W'(1);
                end
                if (pop) begin
                    sent_q <= sent_q + WB_LEN_W'(1);
                end
            end
        end
    end

    // p1..pRD_LAT: read-valid delay matching the buffer latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= wb_en_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    wb_skid_fifo #(
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (bp_out_buf_wb_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_cnt)
    );

    assign bp_out_buf_wb_en   = wb_en_q;
    assign bp_out_buf_wb_addr = wb_addr_q;
    assign m_data             = head_data;
    assign bp_wb_tile_end     = tile_end_q;

endmodule

// File: tb/tb_dsp_ctrl_wb.sv
// Scoreboard bench for dsp_ctrl_wb with a fixed-latency buffer model.
module tb_dsp_ctrl_wb;

    localparam int AW = 10;
    localparam int OW = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [23:0]   len = '0;
    logic          en;
    logic [AW-1:0] addr;
    logic [OW-1:0] rdata;
    logic          m_valid, m_last, busy, tend;
    logic          m_ready = 1'b0;
    logic [OW-1:0] m_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0, pop_cnt = 0, end_cnt = 0;
    int first_en = -1, first_vld = -1, last_cyc = -1;
    bit mon_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic [OW-1:0] rd_pipe0 = '0, rd_pipe1 = '0;

    logic [AW-1:0] addr_q [$];
    logic [OW:0]   exp_q  [$];

    dsp_ctrl_wb #(
        .BP_OUT_BUF_DEPTH (AW),
        .OUT_W            (OW),
        .RD_LAT           (2),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bp_wb_tile_start   (start),
        .bp_wb_base         (base),
        .bp_wb_len          (len),
        .bp_out_buf_wb_en   (en),
        .bp_out_buf_wb_addr (addr),
        .bp_out_buf_wb_data (rdata),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .m_data             (m_data),
        .m_last             (m_last),
        .bp_wb_busy         (busy),
        .bp_wb_tile_end     (tend)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [OW-1:0] word_of(input logic [AW-1:0] a);
        logic [OW-1:0] w;
        for (int i = 0; i < OW / 32; i++) begin
            w[32*i +: 32] = ((32'(a) + 32'd7) * 32'h9E3779B1) ^ (32'(i) << 20);
        end
        return w;
    endfunction

    // Output buffer: data valid two cycles after the read enable.
    always @(posedge clk) begin
        rd_pipe0 <= word_of(addr);
        rd_pipe1 <= rd_pipe0;
    end
    assign rdata = rd_pipe1;

    task automatic check_val(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [OW:0]   e;
        logic [AW-1:0] a;
        if (mon_en && rst_n) begin
            if (en) begin
                if (addr_q.size() == 0) begin
                    check_val("extra_read", OW'(1), OW'(0));
                end else begin
                    a = addr_q.pop_front();
                    check_val("rd_addr", OW'(addr), OW'(a));
                end
                if (first_en < 0) first_en = cyc;
                rd_cnt++;
            end
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (stall_prev) begin
                check_val("stall_valid", OW'(m_valid), OW'(1));
                check_val("stall_data", m_data, prev_data);
            end
            if (rd_cnt != pop_cnt)
                check_val("occupancy", OW'((rd_cnt - pop_cnt) <= 4), OW'(1));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_word", OW'(1), OW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_val("m_data", m_data, e[OW-1:0]);
                    check_val("m_last", OW'(m_last), OW'(e[OW]));
                end
                if (m_last) last_cyc = cyc;
                pop_cnt++;
            end
            if (tend) end_cnt++;
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_wb_en"}, OW'(en), OW'(0));
        check_val({tag, "_wb_addr"}, OW'(addr), OW'(0));
        check_val({tag, "_m_valid"}, OW'(m_valid), OW'(0));
        check_val({tag, "_m_data"}, m_data, OW'(0));
        check_val({tag, "_m_last"}, OW'(m_last), OW'(0));
        check_val({tag, "_busy"}, OW'(busy), OW'(0));
        check_val({tag, "_tile_end"}, OW'(tend), OW'(0));
    endtask

    task automatic expect_tile(input logic [AW-1:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            addr_q.push_back(AW'(32'(b) + k));
            exp_q.push_back({(k == n - 1), word_of(AW'(32'(b) + k))});
        end
    endtask

    // mode 0: ready always high, 1: ready toggles, 2: ready low for 20 cycles
    task automatic run_tile(input logic [AW-1:0] b, input int n, input int mode, input bit inj);
        int st_cyc;
        int end_cyc;
        rd_cnt = 0; pop_cnt = 0; end_cnt = 0;
        first_en = -1; first_vld = -1; last_cyc = -1;
        expect_tile(b, n);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = 24'(n);
        m_ready = (mode != 2);
        st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; base = '0; len = '0;
        end_cyc = -1;
        for (int it = 1; it <= 300 && end_cyc < 0; it++) begin
            if (mode == 1) m_ready = it[0];
            if (mode == 2) m_ready = (it > 20);
            if (inj && it == 3) begin
                start = 1'b1; base = AW'(10'h3F0); len = 24'd5;
            end
            if (inj && it == 4) begin
                start = 1'b0; base = '0; len = '0;
            end
            @(negedge clk);
            if (tend) begin
                check_val("busy_at_end", OW'(busy), OW'(0));
                end_cyc = cyc;
            end else if (n != 0) begin
                check_val("busy_in_tile", OW'(busy), OW'(1));
            end
            if (mode == 2 && it == 20) check_val("reads_while_stalled", OW'(rd_cnt), OW'(4));
            @(posedge clk); #1;
        end
        if (end_cyc < 0) begin
            check_val("tile_timeout", OW'(0), OW'(1));
        end else begin
            check_val("end_latency", OW'((n == 0) ? (end_cyc - st_cyc) : (end_cyc - last_cyc)), OW'(1));
        end
        @(negedge clk);
        check_val("end_single", OW'(tend), OW'(0));
        check_val("end_count", OW'(end_cnt), OW'(1));
        check_val("words_left", OW'(exp_q.size()), OW'(0));
        check_val("addrs_left", OW'(addr_q.size()), OW'(0));
        check_val("read_count", OW'(rd_cnt), OW'(n));
        if (n > 0) begin
            check_val("wb_en_latency", OW'(first_en - st_cyc), OW'(2));
            check_val("m_valid_latency", OW'(first_vld - first_en), OW'(3));
            if (mode == 0) check_val("throughput", OW'(last_cyc - first_vld), OW'(n - 1));
        end else begin
            check_val("no_m_valid", OW'(first_vld < 0), OW'(1));
        end
    endtask

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_tile(AW'(10'h010), 8, 0, 1'b1);
        run_tile(AW'(10'h040), 16, 1, 1'b0);
        run_tile(AW'(10'h080), 10, 2, 1'b0);
        run_tile(AW'(10'h123), 0, 0, 1'b0);
        run_tile(AW'((1 << AW) - 2), 4, 0, 1'b0);

        // Abort a tile after three words with a synchronous reset.
        rd_cnt = 0; pop_cnt = 0;
        expect_tile(AW'(10'h100), 8);
        @(posedge clk); #1;
        start = 1'b1; base = AW'(10'h100); len = 24'd8; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base = '0; len = '0;
        guard = 0;
        while (pop_cnt < 3 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("abort_reached", OW'(pop_cnt >= 3), OW'(1));
        rst_n = 1'b0;
        mon_en = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            if (r > 0) check_outputs_zero("midreset");
        end
        addr_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        end_cnt = 0;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            check_val("no_stale_valid", OW'(m_valid), OW'(0));
        end
        check_val("no_abort_end", OW'(end_cnt), OW'(0));

        run_tile(AW'(10'h200), 2, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
